// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array feed scheduler:
// FSM encoding, lane count and the round-robin lane picker.
package sa_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam int ROWS           = 3;
  localparam int DATA_WIDTH_DEF = 8;

  // Returns {found, lane}: first non-empty lane at or after ptr, wrapping.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [ROWS-1:0] empty);
    logic [2:0] r;
    int         l;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      l = (int'(ptr) + i) % ROWS;
      if (!empty[l]) r = {1'b1, 2'(l)};
    end
    return r;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Registered DEPTH-cycle delay line for one lane's en/idx bundle.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sa_feed_sched.sv
// Feed scheduler for a 3-row systolic array: skewed operand feed, flush, and
// optional round-robin output drain (enabled by macro SA_FEED_DRAIN_EN).
module sa_feed_sched
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VEC_LEN    = 28,
  parameter int IW         = 10,
  parameter int PIPE_LAT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              num_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              ifm_en,
  output logic [2:0]              w_en,
  output logic [IW-1:0]           ifm_idx0,
  output logic [IW-1:0]           ifm_idx1,
  output logic [IW-1:0]           ifm_idx2,
  output logic [IW-1:0]           w_idx0,
  output logic [IW-1:0]           w_idx1,
  output logic [IW-1:0]           w_idx2,
  output logic [2:0]              obf_rd_en,
  input  logic [2:0]              obf_empty,
  input  logic [2:0]              obf_err,
  input  logic [2*DATA_WIDTH-1:0] obf_out0,
  input  logic [2*DATA_WIDTH-1:0] obf_out1,
  input  logic [2*DATA_WIDTH-1:0] obf_out2,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [1:0]              out_lane,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int DW2 = 2 * DATA_WIDTH;
  localparam int LW  = 2 * IW + 2;

  state_e        state_q, state_d;
  logic [3:0]    nvec_q, nvec_d;
  logic [15:0]   cnt_q, cnt_d, total;
  logic          en0_q, en0_d;
  logic [IW-1:0] ifm0_q, ifm0_d, w0_q, w0_d;
  logic          err_q, err_d, done_q, done_d;
  logic          start_acc, drain_fin;
  logic [LW-1:0] lane [ROWS];

  assign start_acc = (state_q == S_IDLE) && start;
  assign total     = 16'(32'(nvec_q) * VEC_LEN);

  always_comb begin
    state_d = state_q;
    nvec_d  = nvec_q;
    cnt_d   = cnt_q;
    en0_d   = 1'b0;
    ifm0_d  = ifm0_q;
    w0_d    = w0_q;
    err_d   = err_q | (|obf_err);
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nvec_d = num_vec;
          cnt_d  = '0;
          err_d  = |obf_err;
          ifm0_d = '0;
          w0_d   = '0;
          if (num_vec == 4'd0) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_FEED;
            en0_d   = 1'b1;
          end
        end
      end
      S_FEED: begin
        cnt_d = cnt_q + 16'd1;
        // Lane 0 is registered, so en/idx for cycle c+1 are computed in cycle c.
        if (cnt_q + 16'd1 < total) begin
          en0_d  = 1'b1;
          ifm0_d = ifm0_q + IW'(1);
          w0_d   = (w0_q == IW'(VEC_LEN - 1)) ? '0 : w0_q + IW'(1);
        end
        if (cnt_q == total + 16'd1) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(PIPE_LAT - 1)) begin
          cnt_d = '0;
`ifdef SA_FEED_DRAIN_EN
          state_d = S_DRAIN;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      S_DRAIN: begin
        if (drain_fin) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      nvec_q  <= '0;
      cnt_q   <= '0;
      en0_q   <= 1'b0;
      ifm0_q  <= '0;
      w0_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nvec_q  <= nvec_d;
      cnt_q   <= cnt_d;
      en0_q   <= en0_d;
      ifm0_q  <= ifm0_d;
      w0_q    <= w0_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Bundle layout: {ifm_en, w_en, ifm_idx, w_idx}; lanes 1..2 are delayed copies.
  assign lane[0] = {en0_q, en0_q, ifm0_q, w0_q};

  for (genvar k = 1; k < ROWS; k++) begin : g_skew
    sa_skew_line #(.W(LW), .DEPTH(k)) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i (lane[0]),
      .q_o (lane[k])
    );
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_en
    assign ifm_en[k] = lane[k][LW-1];
    assign w_en[k]   = lane[k][LW-2];
  end

  assign ifm_idx0 = lane[0][2*IW-1:IW];
  assign ifm_idx1 = lane[1][2*IW-1:IW];
  assign ifm_idx2 = lane[2][2*IW-1:IW];
  assign w_idx0   = lane[0][IW-1:0];
  assign w_idx1   = lane[1][IW-1:0];
  assign w_idx2   = lane[2][IW-1:0];

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

`ifdef SA_FEED_DRAIN_EN
  logic [1:0]     rr_q, rr_d, rdl_q, rdl_d, ol_q, ol_d;
  logic [2:0]     rd_q, rd_d, pick;
  logic           ov_q, ov_d, in_drain;
  logic [DW2-1:0] od_q, od_d, obf_sel;

  assign in_drain = (state_q == S_DRAIN);
  assign pick     = rr_pick(rr_q, obf_empty);

  always_comb begin
    case (rdl_q)
      2'd1:    obf_sel = obf_out1;
      2'd2:    obf_sel = obf_out2;
      default: obf_sel = obf_out0;
    endcase
  end

  // Buffers are first-word-fall-through: data is taken from the head during
  // the rd_en cycle, and the buffer pops on that same edge.
  always_comb begin
    rr_d  = rr_q;
    rdl_d = rdl_q;
    rd_d  = '0;
    ov_d  = ov_q;
    od_d  = od_q;
    ol_d  = ol_q;
    if (start_acc) rr_d = '0;
    if (ov_q && out_ready) ov_d = 1'b0;
    if (|rd_q) begin
      od_d = obf_sel;
      ol_d = rdl_q;
      ov_d = 1'b1;
    end
    if (in_drain && !(|rd_q) && (!ov_q || out_ready) && pick[2]) begin
      rd_d  = 3'b001 << pick[1:0];
      rdl_d = pick[1:0];
      rr_d  = (pick[1:0] == 2'(ROWS - 1)) ? 2'd0 : pick[1:0] + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      rdl_q <= '0;
      rd_q  <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      rdl_q <= rdl_d;
      rd_q  <= rd_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      ol_q  <= ol_d;
    end
  end

  assign drain_fin = in_drain && (&obf_empty) && !(|rd_q) && !ov_q;
  assign obf_rd_en = rd_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_lane  = ol_q;
`else
  logic unused_drain;
  assign unused_drain = ^{obf_empty, obf_out0, obf_out1, obf_out2, out_ready};
  assign drain_fin    = 1'b0;
  assign obf_rd_en    = '0;
  assign out_valid    = 1'b0;
  assign out_data     = '0;
  assign out_lane     = '0;
`endif

endmodule

// File: tb/tb_sa_feed_sched.sv
// Directed bench for sa_feed_sched; drain checks are compiled when SA_FEED_DRAIN_EN is set.
module tb_sa_feed_sched;
  localparam int DW = 8, VL = 28, IW = 10, PL = 8;
`ifdef SA_FEED_DRAIN_EN
  localparam int DX = 1;
`else
  localparam int DX = 0;
`endif

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [3:0]      num_vec = '0;
  logic            busy, done, err, out_valid;
  logic [2:0]      ifm_en, w_en, obf_rd_en, obf_empty, obf_err;
  logic [IW-1:0]   ifm_idx0, ifm_idx1, ifm_idx2, w_idx0, w_idx1, w_idx2;
  logic [2*DW-1:0] obf_out0, obf_out1, obf_out2, out_data;
  logic [1:0]      out_lane;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  sa_feed_sched #(.DATA_WIDTH(DW), .VEC_LEN(VL), .IW(IW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done), .err(err), .ifm_en(ifm_en), .w_en(w_en),
    .ifm_idx0(ifm_idx0), .ifm_idx1(ifm_idx1), .ifm_idx2(ifm_idx2),
    .w_idx0(w_idx0), .w_idx1(w_idx1), .w_idx2(w_idx2),
    .obf_rd_en(obf_rd_en), .obf_empty(obf_empty), .obf_err(obf_err),
    .obf_out0(obf_out0), .obf_out1(obf_out1), .obf_out2(obf_out2),
    .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready)
  );

  // First-word-fall-through output buffer model, 8 deep per lane.
  logic [15:0] fmem [3][8];
  int wrp [3] = '{0, 0, 0};
  int rdp [3] = '{0, 0, 0};

  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (obf_rd_en[k] && rdp[k] != wrp[k]) rdp[k] <= rdp[k] + 1;

  assign obf_empty = {rdp[2] == wrp[2], rdp[1] == wrp[1], rdp[0] == wrp[0]};
  assign obf_out0  = fmem[0][rdp[0] % 8];
  assign obf_out1  = fmem[1][rdp[1] % 8];
  assign obf_out2  = fmem[2][rdp[2] % 8];

  task automatic push(input int k, input logic [15:0] d);
    fmem[k][wrp[k] % 8] = d;
    wrp[k] = wrp[k] + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle history of one run; index i is the i-th cycle after start was sampled.
  logic [2:0]    en_h [0:127], wen_h [0:127];
  logic [IW-1:0] w0_h [0:127], i0_h [0:127], i2_h [0:127];
  logic          done_h [0:127], err_h [0:127], busy_h [0:127];
  logic [2:0]    rd_any = '0;
  logic          ov_any = 1'b0;

  task automatic run(input logic [3:0] nv, input int err_at, input int restart_at, input int ncyc);
    for (int i = 0; i < 128; i++) begin
      en_h[i] = '0; wen_h[i] = '0; w0_h[i] = '0; i0_h[i] = '0; i2_h[i] = '0;
      done_h[i] = 1'b0; err_h[i] = 1'b0; busy_h[i] = 1'b0;
    end
    @(negedge clk);
    num_vec = nv;
    start   = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      en_h[i] = ifm_en; wen_h[i] = w_en; w0_h[i] = w_idx0; i0_h[i] = ifm_idx0;
      i2_h[i] = ifm_idx2; done_h[i] = done; err_h[i] = err; busy_h[i] = busy;
      rd_any  = rd_any | obf_rd_en;
      ov_any  = ov_any | out_valid;
      start   = (i == restart_at);
      if (start) num_vec = 4'd5;
      obf_err = (i == err_at) ? 3'b010 : 3'b000;
    end
    start = 1'b0;
  endtask

  function automatic int first_hi(input int k);
    for (int i = 1; i < 128; i++) if (en_h[i][k]) return i;
    return -1;
  endfunction

  function automatic int last_hi(input int k);
    for (int i = 127; i >= 1; i--) if (en_h[i][k]) return i;
    return -1;
  endfunction

  function automatic int done_at();
    for (int i = 1; i < 128; i++) if (done_h[i]) return i;
    return -1;
  endfunction

  task automatic check_run(input string p);
    int nd, nmis, any_en;
    nd = 0; nmis = 0; any_en = 0;
    for (int i = 1; i < 128; i++) begin
      if (done_h[i]) nd++;
      if (wen_h[i] !== en_h[i]) nmis++;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_en%0d_first", p, k), first_hi(k), 1 + k);
      chk($sformatf("%s_en%0d_last", p, k), last_hi(k), 84 + k);
    end
    chk({p, "_wen_eq_ifmen"}, nmis, 0);
    chk({p, "_done_cycle"}, done_at(), 95 + DX);
    chk({p, "_done_pulses"}, nd, 1);
    chk({p, "_busy_before_done"}, busy_h[94 + DX], 1);
    chk({p, "_busy_at_done"}, busy_h[95 + DX], 0);
    chk({p, "_widx0_t28"}, w0_h[28], 27);
    chk({p, "_widx0_t29"}, w0_h[29], 0);
    chk({p, "_ifmidx2_t86"}, i2_h[86], 83);
    chk({p, "_ifmidx0_hold"}, i0_h[100], 83);
    chk({p, "_err_cleared"}, err_h[1], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    obf_err = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy, done, err, ifm_en, w_en, obf_rd_en, out_valid, out_lane}, 0);
    chk("reset_idx", {ifm_idx0, ifm_idx1, ifm_idx2, w_idx0, w_idx1, w_idx2}, 0);
    chk("reset_data", out_data, 0);
    rst = 1'b0;

    // Error pulse mid-FEED stays sticky through done and into IDLE.
    run(4'd3, 40, 0, 110);
    chk("err_pre_pulse", err_h[39], 0);
    chk("err_after_pulse", err_h[41], 1);
    chk("err_at_done", err_h[95 + DX], 1);
    chk("err_in_idle", err_h[110], 1);

    // Nominal run; a start pulse mid-FEED must be ignored.
    run(4'd3, 0, 10, 110);
    check_run("run");

    // num_vec = 0 skips FEED entirely.
    run(4'd0, 0, 0, 20);
    begin
      int act;
      act = 0;
      for (int i = 1; i <= 20; i++) if (en_h[i] != 3'b000 || wen_h[i] != 3'b000) act++;
      chk("nv0_no_en", act, 0);
      chk("nv0_done_cycle", done_at(), 9 + DX);
    end

    // Reset mid-FEED, then a clean rerun.
    @(negedge clk); num_vec = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    obf_err = 3'b100;
    @(negedge clk); obf_err = 3'b000;
    repeat (10) @(negedge clk);
    chk("mid_feed_err_set", err, 1);
    chk("mid_feed_en_active", ifm_en, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_feed_ctl", {busy, done, err, ifm_en, w_en, obf_rd_en, out_valid, out_lane}, 0);
    chk("rst_feed_idx", {ifm_idx0, ifm_idx1, ifm_idx2, w_idx0, w_idx1, w_idx2}, 0);
    chk("rst_feed_data", out_data, 0);
    rst = 1'b0;
    run(4'd3, 0, 0, 110);
    check_run("post_rst");

`ifdef SA_FEED_DRAIN_EN
    begin
      logic [1:0]  acc_l [0:7];
      logic [15:0] acc_d [0:7];
      logic [15:0] first_data;
      int nacc, hold, stable_bad, rd_stall, dcyc, seen;
      nacc = 0; hold = 0; stable_bad = 0; rd_stall = 0; dcyc = -1; first_data = '0;
      push(0, 16'h0011); push(0, 16'h0012); push(2, 16'h0033);
      out_ready = 1'b0;
      @(negedge clk); num_vec = 4'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 1; i <= 200 && dcyc < 0; i++) begin
        if (done) dcyc = i;
        if (out_valid) begin
          if (out_ready) begin
            if (nacc < 8) begin acc_l[nacc] = out_lane; acc_d[nacc] = out_data; end
            nacc++;
          end else begin
            if (hold == 0) first_data = out_data;
            else if (out_data !== first_data || out_lane !== 2'd0) stable_bad++;
            if (|obf_rd_en) rd_stall++;
            hold++;
          end
        end
        out_ready = (hold >= 5);
        @(negedge clk);
      end
      chk("drain_done_seen", dcyc > 0, 1);
      chk("drain_accepts", nacc, 3);
      chk("drain_lane0", acc_l[0], 0);
      chk("drain_data0", acc_d[0], 16'h0011);
      chk("drain_lane1", acc_l[1], 2);
      chk("drain_data1", acc_d[1], 16'h0033);
      chk("drain_lane2", acc_l[2], 0);
      chk("drain_data2", acc_d[2], 16'h0012);
      chk("drain_stall_cycles", hold, 5);
      chk("drain_stall_stable", stable_bad, 0);
      chk("drain_stall_no_rd", rd_stall, 0);
      chk("drain_idle_after", busy, 0);

      // Reset while an output is held in DRAIN.
      push(1, 16'h0044); push(1, 16'h0055);
      out_ready = 1'b0;
      @(negedge clk); num_vec = 4'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
        if (out_valid) seen = 1;
        else @(negedge clk);
      end
      chk("mid_drain_valid_seen", seen, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_drain_ctl", {busy, done, err, out_valid, obf_rd_en, out_lane}, 0);
      chk("rst_drain_data", out_data, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_drain_no_replay", {out_valid, obf_rd_en, busy}, 0);
    end
`else
    chk("tied_rd_en", rd_any, 0);
    chk("tied_out_valid", ov_any, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
